global_ram_loader: RTL and testbench

Byte-stream loader that sits directly upstream of the fused-block top (`Top_Global_Fused`) and drives its global-BRAM initial-load port. It accepts a host/DMA byte stream and packs 16 bytes into each 128-bit word, first byte in the most-significant lane. It writes the words to consecutive global-RAM addresses starting at a programmed base. When the programmed byte count has been written, it ends the load phase and pulses `start`.

---
 rtl/global_loader_pkg.sv | 28 ++
 rtl/global_ram_loader_byte_packer.sv | 71 +++++++
 rtl/global_ram_loader.sv | 187 ++++++++++++++++++
 tb/tb_global_ram_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/global_loader_pkg.sv
// ---------------------------------------------------------------------------
// global_loader_pkg
//
// Shared definitions for the global-RAM byte-stream loader:
//   WORD_BYTES     - bytes packed into one global-RAM word (16)
//   LANE_W         - width of the lane index that walks those bytes
//   loader_state_t - loader FSM state encoding
//   lane_of()      - maps a stream position inside a word to its byte lane
// ---------------------------------------------------------------------------
package global_loader_pkg;

    localparam int WORD_BYTES = 16;
    localparam int LANE_W     = $clog2(WORD_BYTES);
    localparam int WORD_W     = 8 * WORD_BYTES;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

    // The first byte of a word lands in the most-significant lane.
    function automatic int lane_of(input int pos);
        return WORD_BYTES - 1 - pos;
    endfunction

endpackage

// File: rtl/global_ram_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
//
// Packs a byte stream into WORD_W-bit words, first byte in the top lane.
//
// Ports:
//   clk         in   clock
//   reset       in   synchronous active-high reset
//   clear_i     in   discard any partial word and restart at lane 0
//   accept_i    in   a byte is consumed this cycle
//   byte_i      in   the byte being consumed
//   idx_o       out  stream position of the next byte inside the word
//   word_o      out  current word with byte_i merged in (meaningful with accept_i)
//   word_done_o out  accept_i on the 16th byte of a word
// ---------------------------------------------------------------------------
module byte_packer
    import global_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              accept_i,
    input  logic [7:0]        byte_i,
    output logic [LANE_W-1:0] idx_o,
    output logic [WORD_W-1:0] word_o,
    output logic              word_done_o
);

    logic [LANE_W-1:0] idx_q, idx_d;
    logic [WORD_W-1:0] pack_q, pack_d;
    logic [WORD_W-1:0] merged;

    // Each lane either takes the incoming byte (when the index points at it)
    // or keeps what was already packed. Lanes not yet reached stay zero, so
    // a partial word is already zero-padded.
    generate
        for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            assign merged[8*gi +: 8] =
                (idx_q == LANE_W'(lane_of(gi))) ? byte_i : pack_q[8*gi +: 8];
        end
    endgenerate

    assign word_done_o = accept_i && (idx_q == LANE_W'(WORD_BYTES - 1));
    assign word_o      = merged;
    assign idx_o       = idx_q;

    always_comb begin
        idx_d  = idx_q;
        pack_d = pack_q;
        if (clear_i) begin
            idx_d  = '0;
            pack_d = '0;
        end else if (accept_i) begin
            // Index wraps 15 -> 0 naturally; the finished word has already
            // been handed out via word_o, so the register restarts empty.
            idx_d  = idx_q + LANE_W'(1);
            pack_d = word_done_o ? '0 : merged;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q  <= '0;
            pack_q <= '0;
        end else begin
            idx_q  <= idx_d;
            pack_q <= pack_d;
        end
    end

endmodule

// File: rtl/global_ram_loader.sv
// ---------------------------------------------------------------------------
// global_ram_loader
//
// Accepts a host/DMA byte stream, packs 16 bytes per 128-bit word and writes
// the words to consecutive global-RAM addresses from a programmed base. When
// the programmed byte count has been written it drops load_phase and pulses
// start for one cycle.
//
// Optional feature macro: GLOBAL_LOADER_CHECKSUM_EN adds output checksum, the
// modulo-2^32 sum of all bytes accepted during the current load.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   cfg_valid               pulse: latch config and start a load (IDLE only)
//   cfg_base_addr           first word address
//   cfg_num_bytes           number of bytes to load
//   in_valid/in_byte        stream byte, consumed when in_valid && in_ready
//   in_ready                high while loading
//   load_phase              high from config accept through the final write
//   we_global_initial       one-cycle write strobe per word
//   wr_addr_global_initial  word address, valid with the strobe
//   data_load_in_global     packed word, valid with the strobe
//   start                   one-cycle pulse after the final write
//   busy                    loader not idle
//   checksum                (macro only) running byte sum
// ---------------------------------------------------------------------------
module global_ram_loader
    import global_loader_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [31:0]       cfg_num_bytes,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              load_phase,
    output logic              we_global_initial,
    output logic [ADDR_W-1:0] wr_addr_global_initial,
    output logic [DATA_W-1:0] data_load_in_global,
    output logic              start,
`ifdef GLOBAL_LOADER_CHECKSUM_EN
    output logic              busy,
    output logic [31:0]       checksum
`else
    output logic              busy
`endif
);

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic [31:0]       num_q, num_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              accept;
    logic              cfg_accept;
    logic              last_byte;
    logic              word_done;
    logic [LANE_W-1:0] lane_idx;
    logic [WORD_W-1:0] packed_word;

    assign in_ready   = (state_q == LOAD);
    assign accept     = in_valid && in_ready;
    assign cfg_accept = cfg_valid && (state_q == IDLE);
    // Only evaluated in LOAD, where num_q is known to be non-zero.
    assign last_byte  = accept && (cnt_q == num_q - 32'd1);

    byte_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (cfg_accept),
        .accept_i    (accept),
        .byte_i      (in_byte),
        .idx_o       (lane_idx),
        .word_o      (packed_word),
        .word_done_o (word_done)
    );

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        offset_d = offset_q;
        num_d    = num_q;
        cnt_d    = cnt_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        unique case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    base_d   = cfg_base_addr;
                    num_d    = cfg_num_bytes;
                    cnt_d    = '0;
                    offset_d = '0;
                    state_d  = (cfg_num_bytes == 32'd0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    cnt_d = cnt_q + 32'd1;
                    // A full word, or the final (possibly partial) word, is
                    // written directly from the merged view so the strobe
                    // appears the cycle after the handshake.
                    if (word_done || last_byte) begin
                        we_d     = 1'b1;
                        addr_d   = base_q + offset_q;
                        data_d   = DATA_W'(packed_word);
                        offset_d = offset_q + ADDR_W'(1);
                    end
                    if (last_byte) begin
                        state_d = FLUSH;
                    end
                end
            end
            // Cycle in which the final write strobe is visible, whether the
            // last word was full or zero-padded.
            FLUSH: state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            base_q   <= '0;
            offset_q <= '0;
            num_q    <= '0;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            offset_q <= offset_d;
            num_q    <= num_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

`ifdef GLOBAL_LOADER_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (cfg_accept) begin
            csum_d = '0;
        end else if (accept) begin
            csum_d = csum_q + {24'd0, in_byte};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`endif

    assign load_phase             = (state_q == LOAD) || (state_q == FLUSH);
    assign start                  = (state_q == DONE);
    assign busy                   = (state_q != IDLE);
    assign we_global_initial      = we_q;
    assign wr_addr_global_initial = addr_q;
    assign data_load_in_global    = data_q;

    // lane_idx is exposed by the packer for debug visibility only.
    logic unused_lane_idx;
    assign unused_lane_idx = ^lane_idx;

endmodule

// File: tb/tb_global_ram_loader.sv
// ---------------------------------------------------------------------------
// tb_global_ram_loader
//
// Directed bench for global_ram_loader. A negedge monitor logs every write
// strobe and start pulse (one line each); scenario tasks drive a load and
// compare the logged transactions against hand-computed values.
// Build with GLOBAL_LOADER_CHECKSUM_EN to include the checksum scenario.
// ---------------------------------------------------------------------------
module tb_global_ram_loader;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_valid;
    logic [ADDR_W-1:0] cfg_base_addr;
    logic [31:0]       cfg_num_bytes;
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_ready;
    logic              load_phase;
    logic              we_global_initial;
    logic [ADDR_W-1:0] wr_addr_global_initial;
    logic [DATA_W-1:0] data_load_in_global;
    logic              start;
    logic              busy;
`ifdef GLOBAL_LOADER_CHECKSUM_EN
    logic [31:0]       checksum;
`endif

    always #5 clk = ~clk;

    global_ram_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .cfg_valid              (cfg_valid),
        .cfg_base_addr          (cfg_base_addr),
        .cfg_num_bytes          (cfg_num_bytes),
        .in_valid               (in_valid),
        .in_byte                (in_byte),
        .in_ready               (in_ready),
        .load_phase             (load_phase),
        .we_global_initial      (we_global_initial),
        .wr_addr_global_initial (wr_addr_global_initial),
        .data_load_in_global    (data_load_in_global),
        .start                  (start),
`ifdef GLOBAL_LOADER_CHECKSUM_EN
        .busy                   (busy),
        .checksum               (checksum)
`else
        .busy                   (busy)
`endif
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [ADDR_W-1:0] w_addr[$];
    logic [DATA_W-1:0] w_data[$];
    int                w_cyc[$];
    int                s_cyc[$];
    logic              s_lp[$];

    int n_checks = 0;
    int n_pass   = 0;

    always @(negedge clk) begin
        if (we_global_initial === 1'b1) begin
            w_addr.push_back(wr_addr_global_initial);
            w_data.push_back(data_load_in_global);
            w_cyc.push_back(cyc);
            $display("write cyc=%0d addr=%08h data=%032h", cyc, wr_addr_global_initial, data_load_in_global);
        end
        if (start === 1'b1) begin
            s_cyc.push_back(cyc);
            s_lp.push_back(load_phase);
            $display("start cyc=%0d load_phase=%0b", cyc, load_phase);
        end
    end

    task automatic clear_log();
        w_addr.delete(); w_data.delete(); w_cyc.delete(); s_cyc.delete(); s_lp.delete();
    endtask

    // Entered and left at posedge+1. cfg_cyc is the cycle count just before
    // the accepting edge.
    task automatic do_cfg(input logic [31:0] base, input logic [31:0] n, output int cfg_cyc);
        cfg_valid = 1'b1; cfg_base_addr = base; cfg_num_bytes = n;
        @(negedge clk);
        cfg_cyc = cyc;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    // Sends n bytes (first, first+1, ... or constant when inc=0). With gaps,
    // in_valid drops randomly. bogus_at >= 0 raises cfg_valid on that cycle.
    task automatic send_stream(input int n, input logic [7:0] first, input bit inc,
                               input bit gaps, input int bogus_at);
        int sent = 0;
        int it = 0;
        while (sent < n && it < 2000) begin
            in_valid      = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_byte       = inc ? 8'(int'(first) + sent) : first;
            cfg_valid     = (it == bogus_at);
            cfg_base_addr = 32'hDEAD; cfg_num_bytes = 32'd3;
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
            it++;
        end
        in_valid = 1'b0; cfg_valid = 1'b0;
        n_checks++;
        if (sent != n) $display("FAIL stream_timeout: sent %0d bytes, required %0d", sent, n);
        else n_pass++;
    endtask

    task automatic wait_done();
        int g = 0;
        while (s_cyc.size() == 0 && g < 60) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (s_cyc.size() != 1) $display("FAIL start_count: got %0d pulses, required 1", s_cyc.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1; cfg_valid = 1'b0; in_valid = 1'b0; in_byte = '0;
        cfg_base_addr = '0; cfg_num_bytes = '0;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if ({we_global_initial, start, load_phase, busy, in_ready, wr_addr_global_initial, data_load_in_global} !== '0)
            $display("FAIL reset_outputs: got we=%b start=%b lp=%b busy=%b rdy=%b, required all 0",
                     we_global_initial, start, load_phase, busy, in_ready);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_aligned();
        int c;
        clear_log();
        do_cfg(32'h0, 32'd32, c);
        send_stream(32, 8'h00, 1'b1, 1'b0, -1);
        wait_done();
        n_checks++; if (w_addr.size() != 2) $display("FAIL aligned_nwrites: got %0d, required 2", w_addr.size()); else n_pass++;
        n_checks++; if (w_addr[0] !== 32'h0) $display("FAIL aligned_addr0: got %h, required 0", w_addr[0]); else n_pass++;
        n_checks++; if (w_data[0] !== 128'h000102030405060708090a0b0c0d0e0f) $display("FAIL aligned_data0: got %h", w_data[0]); else n_pass++;
        n_checks++; if (w_cyc[0] != c + 17) $display("FAIL aligned_latency0: got cyc %0d, required %0d", w_cyc[0], c + 17); else n_pass++;
        n_checks++; if (w_addr[1] !== 32'h1) $display("FAIL aligned_addr1: got %h, required 1", w_addr[1]); else n_pass++;
        n_checks++; if (w_data[1] !== 128'h101112131415161718191a1b1c1d1e1f) $display("FAIL aligned_data1: got %h", w_data[1]); else n_pass++;
        n_checks++; if (w_cyc[1] != c + 33) $display("FAIL aligned_latency1: got cyc %0d, required %0d", w_cyc[1], c + 33); else n_pass++;
        n_checks++; if (s_cyc[0] != c + 34) $display("FAIL aligned_start_cyc: got %0d, required %0d", s_cyc[0], c + 34); else n_pass++;
        n_checks++; if (s_lp[0] !== 1'b0) $display("FAIL aligned_lp_at_start: got %b, required 0", s_lp[0]); else n_pass++;
        n_checks++; if ({busy, in_ready, load_phase, we_global_initial} !== 4'b0) $display("FAIL aligned_idle_after: got %b, required 0000", {busy, in_ready, load_phase, we_global_initial}); else n_pass++;
    endtask

    task automatic test_partial();
        int c;
        clear_log();
        do_cfg(32'h24BFF, 32'd20, c);
        send_stream(20, 8'h00, 1'b1, 1'b0, -1);
        wait_done();
        n_checks++; if (w_addr.size() != 2) $display("FAIL partial_nwrites: got %0d, required 2", w_addr.size()); else n_pass++;
        n_checks++; if (w_addr[0] !== 32'h24BFF) $display("FAIL partial_addr0: got %h, required 24bff", w_addr[0]); else n_pass++;
        n_checks++; if (w_data[0] !== 128'h000102030405060708090a0b0c0d0e0f) $display("FAIL partial_data0: got %h", w_data[0]); else n_pass++;
        n_checks++; if (w_addr[1] !== 32'h24C00) $display("FAIL partial_addr1: got %h, required 24c00", w_addr[1]); else n_pass++;
        n_checks++; if (w_data[1] !== 128'h10111213000000000000000000000000) $display("FAIL partial_data1: got %h", w_data[1]); else n_pass++;
        n_checks++; if (w_cyc[1] != c + 21) $display("FAIL partial_flush_cyc: got %0d, required %0d", w_cyc[1], c + 21); else n_pass++;
        n_checks++; if (s_cyc[0] != c + 22) $display("FAIL partial_start_cyc: got %0d, required %0d", s_cyc[0], c + 22); else n_pass++;
    endtask

    task automatic test_backpressure();
        int c;
        clear_log();
        do_cfg(32'h40, 32'd48, c);
        send_stream(48, 8'h00, 1'b1, 1'b1, -1);
        wait_done();
        n_checks++; if (w_addr.size() != 3) $display("FAIL bp_nwrites: got %0d, required 3", w_addr.size()); else n_pass++;
        n_checks++; if (w_addr[0] !== 32'h40 || w_addr[1] !== 32'h41 || w_addr[2] !== 32'h42)
            $display("FAIL bp_addrs: got %h %h %h, required 40 41 42", w_addr[0], w_addr[1], w_addr[2]); else n_pass++;
        n_checks++; if (w_data[0] !== 128'h000102030405060708090a0b0c0d0e0f) $display("FAIL bp_data0: got %h", w_data[0]); else n_pass++;
        n_checks++; if (w_data[1] !== 128'h101112131415161718191a1b1c1d1e1f) $display("FAIL bp_data1: got %h", w_data[1]); else n_pass++;
        n_checks++; if (w_data[2] !== 128'h202122232425262728292a2b2c2d2e2f) $display("FAIL bp_data2: got %h", w_data[2]); else n_pass++;
        n_checks++; if (s_cyc[0] != w_cyc[2] + 1) $display("FAIL bp_start_cyc: got %0d, required %0d", s_cyc[0], w_cyc[2] + 1); else n_pass++;
    endtask

    task automatic test_zero_length();
        int c;
        clear_log();
        do_cfg(32'h77, 32'd0, c);
        wait_done();
        n_checks++; if (w_addr.size() != 0) $display("FAIL zero_nwrites: got %0d, required 0", w_addr.size()); else n_pass++;
        n_checks++; if (s_cyc[0] != c + 1) $display("FAIL zero_start_cyc: got %0d, required %0d", s_cyc[0], c + 1); else n_pass++;
    endtask

    task automatic test_cfg_while_busy();
        int c;
        clear_log();
        do_cfg(32'h50, 32'd16, c);
        send_stream(16, 8'h30, 1'b1, 1'b0, 3);
        wait_done();
        n_checks++; if (w_addr.size() != 1) $display("FAIL busy_nwrites: got %0d, required 1", w_addr.size()); else n_pass++;
        n_checks++; if (w_addr[0] !== 32'h50) $display("FAIL busy_addr: got %h, required 50", w_addr[0]); else n_pass++;
        n_checks++; if (w_data[0] !== 128'h303132333435363738393a3b3c3d3e3f) $display("FAIL busy_data: got %h", w_data[0]); else n_pass++;
    endtask

    task automatic test_addr_wrap();
        int c;
        clear_log();
        do_cfg(32'hFFFFFFFF, 32'd32, c);
        send_stream(32, 8'h00, 1'b1, 1'b0, -1);
        wait_done();
        n_checks++; if (w_addr[0] !== 32'hFFFFFFFF || w_addr[1] !== 32'h0)
            $display("FAIL wrap_addrs: got %h %h, required ffffffff 00000000", w_addr[0], w_addr[1]); else n_pass++;
    endtask

    task automatic test_reset_mid_load();
        int c;
        clear_log();
        do_cfg(32'h10, 32'd16, c);
        send_stream(7, 8'h00, 1'b1, 1'b0, -1);
        // Reset together with a byte handshake and a config pulse.
        reset = 1'b1; in_valid = 1'b1; in_byte = 8'h55;
        cfg_valid = 1'b1; cfg_base_addr = 32'h999; cfg_num_bytes = 32'd5;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if ({we_global_initial, start, load_phase, busy, in_ready, wr_addr_global_initial, data_load_in_global} !== '0)
            $display("FAIL midreset_outputs: got we=%b start=%b lp=%b busy=%b rdy=%b, required all 0",
                     we_global_initial, start, load_phase, busy, in_ready);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0; cfg_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (w_addr.size() != 0 || s_cyc.size() != 0)
            $display("FAIL midreset_no_txn: got %0d writes %0d starts, required 0 0", w_addr.size(), s_cyc.size()); else n_pass++;
        clear_log();
        do_cfg(32'h200, 32'd16, c);
        send_stream(16, 8'hA0, 1'b1, 1'b0, -1);
        wait_done();
        n_checks++; if (w_addr.size() != 1 || w_addr[0] !== 32'h200)
            $display("FAIL midreset_reload_addr: got n=%0d addr=%h, required 1 200", w_addr.size(), w_addr[0]); else n_pass++;
        n_checks++; if (w_data[0] !== 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf) $display("FAIL midreset_reload_data: got %h", w_data[0]); else n_pass++;
    endtask

`ifdef GLOBAL_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int c;
        clear_log();
        do_cfg(32'h0, 32'd16, c);
        send_stream(16, 8'hFF, 1'b0, 1'b0, -1);
        wait_done();
        n_checks++; if (checksum !== 32'h00000FF0) $display("FAIL checksum_value: got %h, required 00000ff0", checksum); else n_pass++;
        n_checks++; if (w_data[0] !== {16{8'hFF}}) $display("FAIL checksum_data: got %h", w_data[0]); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_aligned();
        test_partial();
        test_backpressure();
        test_zero_length();
        test_cfg_while_busy();
        test_addr_wrap();
        test_reset_mid_load();
`ifdef GLOBAL_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
